huffman_mcu_scheduler: RTL and testbench

//  Sequences the Huffman encoder controller across the blocks of each MCU (Y/Cb/Cr) for a whole frame.

---
 rtl/jpeg_pkg.sv | 32 +++
 rtl/dc_diff_unit.sv | 13 +
 rtl/huffman_mcu_scheduler.sv | 152 +++++++++++++++
 tb/tb_huffman_mcu_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG datapath constants, component codes, scheduler state type and helpers.
package jpeg_pkg;
  localparam int PIX_W = 10;
  localparam int NPIX  = 64;
  localparam int BLK_W = PIX_W * NPIX;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BLK, S_LOAD, S_START, S_WAIT_HI, S_WAIT_LO, S_NEXT
  } sched_state_e;

  // Clamp a PIX_W+1 bit signed difference back into PIX_W signed range.
  function automatic logic [PIX_W-1:0] sat10(input logic [PIX_W:0] v);
    logic [PIX_W-1:0] r;
    if (v[PIX_W] == v[PIX_W-1]) r = v[PIX_W-1:0];
    else if (v[PIX_W])          r = {1'b1, {(PIX_W-1){1'b0}}};
    else                        r = {1'b0, {(PIX_W-1){1'b1}}};
    return r;
  endfunction

  function automatic logic [1:0] slot_comp(input logic m420, input logic [2:0] slot);
    logic [1:0] c;
    if (!m420)              c = slot[1:0];
    else if (slot < 3'd4)   c = COMP_Y;
    else if (slot == 3'd4)  c = COMP_CB;
    else                    c = COMP_CR;
    return c;
  endfunction
endpackage

// File: rtl/dc_diff_unit.sv
// Combinational DC difference: dc minus predictor, saturated to the coefficient range.
module dc_diff_unit
  import jpeg_pkg::*;
(
  input  logic [PIX_W-1:0] dc,
  input  logic [PIX_W-1:0] pred,
  output logic [PIX_W-1:0] diff
);
  logic [PIX_W:0] wide;

  assign wide = {dc[PIX_W-1], dc} - {pred[PIX_W-1], pred};
  assign diff = sat10(wide);
endmodule

// File: rtl/huffman_mcu_scheduler.sv
// Walks the Y/Cb/Cr blocks of every MCU in a frame, DC-codes coefficient 0 and
// hands each block to the Huffman encoder controller, holding it until the encoder idles.
module huffman_mcu_scheduler
  import jpeg_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             frame_start,
  input  logic             mode_420,
  input  logic [15:0]      num_mcus,
  input  logic             y_valid,
  input  logic             cb_valid,
  input  logic             cr_valid,
  input  logic [BLK_W-1:0] y_blk,
  input  logic [BLK_W-1:0] cb_blk,
  input  logic [BLK_W-1:0] cr_blk,
  output logic             y_take,
  output logic             cb_take,
  output logic             cr_take,
  input  logic             enc_active,
  output logic             huffman_start,
  output logic             is_luminance,
  output logic [BLK_W-1:0] zigzag_pix_out,
  output logic [1:0]       comp_id,
  output logic             busy,
  output logic             mcu_done,
  output logic             frame_done,
  output logic             frame_err
);
  sched_state_e     state;
  logic             mode_q;
  logic [15:0]      num_mcus_q;
  logic [15:0]      mcu_cnt;
  logic [2:0]       slot;
  logic [PIX_W-1:0] pred [3];

  logic [1:0]       cur_comp;
  logic             cur_valid;
  logic [BLK_W-1:0] cur_blk;
  logic [PIX_W-1:0] cur_pred;
  logic [PIX_W-1:0] dc_diff;
  logic             last_slot;
  logic             last_mcu;

  // Route the buffer and predictor belonging to the current MCU slot.
  always_comb begin
    cur_comp  = slot_comp(mode_q, slot);
    cur_valid = y_valid;
    cur_blk   = y_blk;
    cur_pred  = pred[0];
    case (cur_comp)
      COMP_CB: begin cur_valid = cb_valid; cur_blk = cb_blk; cur_pred = pred[1]; end
      COMP_CR: begin cur_valid = cr_valid; cur_blk = cr_blk; cur_pred = pred[2]; end
      default: ;
    endcase
  end

  assign last_slot = (slot == (mode_q ? 3'd5 : 3'd2));
  assign last_mcu  = (({1'b0, mcu_cnt} + 17'd1) == {1'b0, num_mcus_q});

  dc_diff_unit u_dc_diff (
    .dc   (cur_blk[PIX_W-1:0]),
    .pred (cur_pred),
    .diff (dc_diff)
  );

  // Pulse outputs default low each cycle; data outputs only change on a block load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      mode_q         <= 1'b0;
      num_mcus_q     <= '0;
      mcu_cnt        <= '0;
      slot           <= '0;
      pred[0]        <= '0;
      pred[1]        <= '0;
      pred[2]        <= '0;
      y_take         <= 1'b0;
      cb_take        <= 1'b0;
      cr_take        <= 1'b0;
      huffman_start  <= 1'b0;
      is_luminance   <= 1'b0;
      zigzag_pix_out <= '0;
      comp_id        <= COMP_Y;
      busy           <= 1'b0;
      mcu_done       <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      y_take        <= 1'b0;
      cb_take       <= 1'b0;
      cr_take       <= 1'b0;
      huffman_start <= 1'b0;
      mcu_done      <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= frame_start && (state != S_IDLE);
      case (state)
        S_IDLE: if (frame_start) begin
          mode_q     <= mode_420;
          num_mcus_q <= num_mcus;
          mcu_cnt    <= '0;
          slot       <= '0;
          pred[0]    <= '0;
          pred[1]    <= '0;
          pred[2]    <= '0;
          busy       <= 1'b1;
          state      <= (num_mcus == 16'd0) ? S_NEXT : S_WAIT_BLK;
        end
        S_WAIT_BLK: if (cur_valid) begin
          case (cur_comp)
            COMP_CB: begin cb_take <= 1'b1; pred[1] <= cur_blk[PIX_W-1:0]; end
            COMP_CR: begin cr_take <= 1'b1; pred[2] <= cur_blk[PIX_W-1:0]; end
            default: begin y_take  <= 1'b1; pred[0] <= cur_blk[PIX_W-1:0]; end
          endcase
          zigzag_pix_out <= {cur_blk[BLK_W-1:PIX_W], dc_diff};
          comp_id        <= cur_comp;
          is_luminance   <= (cur_comp == COMP_Y);
          state          <= S_LOAD;
        end
        S_LOAD: begin
          huffman_start <= 1'b1;
          state         <= S_START;
        end
        S_START:   state <= S_WAIT_HI;
        S_WAIT_HI: if (enc_active)  state <= S_WAIT_LO;
        S_WAIT_LO: if (!enc_active) state <= S_NEXT;
        S_NEXT: begin
          if (num_mcus_q == 16'd0) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (last_slot) begin
            slot     <= '0;
            mcu_done <= 1'b1;
            mcu_cnt  <= mcu_cnt + 16'd1;
            if (last_mcu) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end else begin
              state <= S_WAIT_BLK;
            end
          end else begin
            slot  <= slot + 3'd1;
            state <= S_WAIT_BLK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// Bench for huffman_mcu_scheduler: directed frame table, corner sequences and random frames vs a DC model.
module tb_huffman_mcu_scheduler;
  import jpeg_pkg::*;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             frame_start = 1'b0;
  logic             mode_420 = 1'b0;
  logic [15:0]      num_mcus = '0;
  logic             y_valid = 1'b0, cb_valid = 1'b0, cr_valid = 1'b0;
  logic [BLK_W-1:0] y_blk = '0, cb_blk = '0, cr_blk = '0;
  logic             y_take, cb_take, cr_take;
  logic             enc_active = 1'b0;
  logic             huffman_start, is_luminance, busy, mcu_done, frame_done, frame_err;
  logic [BLK_W-1:0] zigzag_pix_out;
  logic [1:0]       comp_id;

  huffman_mcu_scheduler dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .mode_420(mode_420),
    .num_mcus(num_mcus), .y_valid(y_valid), .cb_valid(cb_valid), .cr_valid(cr_valid),
    .y_blk(y_blk), .cb_blk(cb_blk), .cr_blk(cr_blk), .y_take(y_take), .cb_take(cb_take),
    .cr_take(cr_take), .enc_active(enc_active), .huffman_start(huffman_start),
    .is_luminance(is_luminance), .zigzag_pix_out(zigzag_pix_out), .comp_id(comp_id),
    .busy(busy), .mcu_done(mcu_done), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]       comp;
    logic [BLK_W-1:0] blk;
  } exp_t;

  typedef struct {
    string name;
    bit    m420;
    int    n;
    int    dc[12];
    int    ex[12];
  } vec_t;

  int n_checks = 0, n_fails = 0;
  logic [BLK_W-1:0] yq[$], cbq[$], crq[$];
  exp_t expq[$];
  int dc_list[$], exp_list[$];
  int s444[3] = '{0, 1, 2};
  int s420[6] = '{0, 0, 0, 0, 1, 2};
  int start_cnt, take_cnt, mcu_cnt, frame_cnt, err_cnt, hold_err, cur_n;
  int enc_cnt = 0, enc_len = 10;
  bit cb_en = 1'b1, gate_rand = 1'b0;
  logic [BLK_W-1:0] held_blk;
  logic [1:0] held_comp;
  string cur_tag = "init";
  vec_t vecs[4];

  task automatic checkOutput(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic int seq_comp(input bit m420, input int idx);
    return m420 ? s420[idx] : s444[idx];
  endfunction

  function automatic int clamp10(input int v);
    return (v > 511) ? 511 : ((v < -512) ? -512 : v);
  endfunction

  // One clock of environment: buffers, encoder model, scoreboard.
  task automatic step();
    exp_t e;
    @(negedge clock);
    if (y_take) begin
      take_cnt++;
      checkOutput({cur_tag, "_take_y_has_blk"}, yq.size() > 0, 1);
      if (yq.size() > 0) void'(yq.pop_front());
    end
    if (cb_take) begin
      take_cnt++;
      checkOutput({cur_tag, "_take_cb_has_blk"}, cbq.size() > 0, 1);
      if (cbq.size() > 0) void'(cbq.pop_front());
    end
    if (cr_take) begin
      take_cnt++;
      checkOutput({cur_tag, "_take_cr_has_blk"}, crq.size() > 0, 1);
      if (crq.size() > 0) void'(crq.pop_front());
    end
    if (huffman_start) begin
      start_cnt++;
      checkOutput({cur_tag, "_start_expected"}, expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput({cur_tag, "_comp_id"}, comp_id, e.comp);
        checkOutput({cur_tag, "_is_lum"}, is_luminance, e.comp == 2'd0);
        checkOutput({cur_tag, "_blk"}, zigzag_pix_out, e.blk);
        held_blk = e.blk;
        held_comp = e.comp;
      end
      enc_cnt = enc_len;
      enc_active = 1'b1;
    end else if (enc_active) begin
      if (zigzag_pix_out !== held_blk || comp_id !== held_comp) hold_err++;
      enc_cnt--;
      if (enc_cnt <= 0) enc_active = 1'b0;
    end
    if (mcu_done) mcu_cnt++;
    if (frame_done) begin
      frame_cnt++;
      checkOutput({cur_tag, "_fd_with_md"}, mcu_done, cur_n > 0);
    end
    if (frame_err) err_cnt++;
    y_valid  = (yq.size() > 0) && !(gate_rand && $urandom_range(0, 2) == 0);
    cb_valid = (cbq.size() > 0) && cb_en && !(gate_rand && $urandom_range(0, 2) == 0);
    cr_valid = (crq.size() > 0) && !(gate_rand && $urandom_range(0, 2) == 0);
    if (yq.size() > 0)  y_blk  = yq[0];
    if (cbq.size() > 0) cb_blk = cbq[0];
    if (crq.size() > 0) cr_blk = crq[0];
  endtask

  // Queue the frame's blocks, build the expected output list, pulse frame_start.
  task automatic applyStimulus(input bit m420, input int n);
    int len;
    len = m420 ? 6 : 3;
    yq.delete(); cbq.delete(); crq.delete(); expq.delete();
    for (int b = 0; b < n * len; b++) begin
      logic [BLK_W-1:0] blk;
      exp_t e;
      for (int k = 1; k < NPIX; k++) blk[k*PIX_W +: PIX_W] = PIX_W'($urandom);
      blk[PIX_W-1:0] = PIX_W'(dc_list[b]);
      e.comp = 2'(seq_comp(m420, b % len));
      e.blk = blk;
      e.blk[PIX_W-1:0] = PIX_W'(exp_list[b]);
      case (e.comp)
        2'd0:    yq.push_back(blk);
        2'd1:    cbq.push_back(blk);
        default: crq.push_back(blk);
      endcase
      expq.push_back(e);
    end
    start_cnt = 0; take_cnt = 0; mcu_cnt = 0; frame_cnt = 0; err_cnt = 0; hold_err = 0;
    cur_n = n;
    mode_420 = m420; num_mcus = 16'(n); frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    mode_420 = 1'($urandom); num_mcus = 16'($urandom);
  endtask

  task automatic run_frame(input string tag, input bit m420, input int n, input bit stall, input bit inject);
    int nb, s0, t0;
    nb = n * (m420 ? 6 : 3);
    cur_tag = tag;
    applyStimulus(m420, n);
    checkOutput({tag, "_busy"}, busy, 1);
    if (n == 0) begin
      step();
      checkOutput({tag, "_fd_latency"}, frame_cnt, 1);
    end
    if (inject) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      checkOutput({tag, "_frame_err"}, err_cnt, 1);
    end
    if (stall) begin
      for (int c = 0; c < 2000 && !(start_cnt >= 1 && !enc_active); c++) step();
      checkOutput({tag, "_stall_reached"}, start_cnt, 1);
      s0 = start_cnt; t0 = take_cnt;
      repeat (50) step();
      checkOutput({tag, "_stall_starts"}, start_cnt, s0);
      checkOutput({tag, "_stall_takes"}, take_cnt, t0);
      checkOutput({tag, "_stall_busy"}, busy, 1);
      cb_en = 1'b1;
    end
    for (int c = 0; c < 6000 && frame_cnt == 0; c++) step();
    checkOutput({tag, "_frame_done"}, frame_cnt, 1);
    checkOutput({tag, "_starts"}, start_cnt, nb);
    checkOutput({tag, "_takes"}, take_cnt, nb);
    checkOutput({tag, "_mcu_done"}, mcu_cnt, n);
    checkOutput({tag, "_left"}, expq.size(), 0);
    checkOutput({tag, "_hold"}, hold_err, 0);
    checkOutput({tag, "_errs"}, err_cnt, inject ? 1 : 0);
    step();
    checkOutput({tag, "_idle"}, busy, 0);
  endtask

  // Reference DC model: per-component predictor of raw DC, saturated difference.
  task automatic build_model(input bit m420, input int n);
    int pred[3];
    int len, c, dc;
    pred = '{0, 0, 0};
    len = m420 ? 6 : 3;
    dc_list.delete(); exp_list.delete();
    for (int b = 0; b < n * len; b++) begin
      c = seq_comp(m420, b % len);
      if ($urandom_range(0, 3) == 0) dc = ($urandom_range(0, 1) != 0) ? 511 : -512;
      else dc = int'($urandom_range(0, 1023)) - 512;
      dc_list.push_back(dc);
      exp_list.push_back(clamp10(dc - pred[c]));
      pred[c] = dc;
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0].name = "basic444"; vecs[0].m420 = 1'b0; vecs[0].n = 1;
    vecs[0].dc = '{20, -5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].ex = '{20, -5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].name = "mode420"; vecs[1].m420 = 1'b1; vecs[1].n = 2;
    vecs[1].dc = '{100, 110, 90, 90, 30, -40, 95, 95, 80, 120, 50, -45};
    vecs[1].ex = '{100, 10, -20, 0, 30, -40, 5, 0, -15, 40, 20, -5};
    vecs[2].name = "sat300"; vecs[2].m420 = 1'b0; vecs[2].n = 3;
    vecs[2].dc = '{-300, 0, 0, 300, 0, 0, -300, 0, 0, 0, 0, 0};
    vecs[2].ex = '{-300, 0, 0, 511, 0, 0, -512, 0, 0, 0, 0, 0};
    vecs[3].name = "extremes"; vecs[3].m420 = 1'b0; vecs[3].n = 2;
    vecs[3].dc = '{511, -512, 0, -512, 511, -1, 0, 0, 0, 0, 0, 0};
    vecs[3].ex = '{511, -512, 0, -512, 511, -1, 0, 0, 0, 0, 0, 0};

    repeat (2) step();
    checkOutput("reset_ctrl", {y_take, cb_take, cr_take, huffman_start, is_luminance, comp_id,
                               busy, mcu_done, frame_done, frame_err}, 0);
    checkOutput("reset_pix", zigzag_pix_out, 0);
    reset_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 4; i++) begin
      dc_list.delete(); exp_list.delete();
      for (int k = 0; k < vecs[i].n * (vecs[i].m420 ? 6 : 3); k++) begin
        dc_list.push_back(vecs[i].dc[k]);
        exp_list.push_back(vecs[i].ex[k]);
      end
      run_frame(vecs[i].name, vecs[i].m420, vecs[i].n, 1'b0, 1'b0);
    end

    cb_en = 1'b0;
    dc_list = '{40, -3, 2}; exp_list = '{40, -3, 2};
    run_frame("stall", 1'b0, 1, 1'b1, 1'b0);

    build_model(1'b1, 1);
    run_frame("busy_err", 1'b1, 1, 1'b0, 1'b1);

    dc_list.delete(); exp_list.delete();
    run_frame("zero", 1'b0, 0, 1'b0, 1'b0);

    cur_tag = "midreset";
    dc_list = '{30, -7, 12}; exp_list = '{30, -7, 12};
    applyStimulus(1'b0, 1);
    for (int c = 0; c < 200 && start_cnt == 0; c++) step();
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_ctrl", {y_take, cb_take, cr_take, huffman_start, is_luminance, comp_id,
                                  busy, mcu_done, frame_done, frame_err}, 0);
    checkOutput("midreset_pix", zigzag_pix_out, 0);
    enc_active = 1'b0; enc_cnt = 0;
    yq.delete(); cbq.delete(); crq.delete(); expq.delete();
    take_cnt = 0; start_cnt = 0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (10) step();
    checkOutput("midreset_no_take", take_cnt, 0);
    checkOutput("midreset_no_start", start_cnt, 0);
    dc_list = '{-9, 4, 100}; exp_list = '{-9, 4, 100};
    run_frame("post_reset", 1'b0, 1, 1'b0, 1'b0);

    gate_rand = 1'b1;
    for (int r = 0; r < 8; r++) begin
      bit m;
      int n;
      m = 1'($urandom);
      n = $urandom_range(1, 3);
      enc_len = $urandom_range(2, 12);
      build_model(m, n);
      run_frame($sformatf("rand%0d", r), m, n, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
